alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised execute-stage ALU for the 5-stage MIPS core. It computes the full single-cycle integer op set combinationally, including correct signed and unsigned compares, shifts and overflow. It also contains an iterative radix-2 multiply/divide unit that writes architectural HI/LO registers. `busy__o` stalls IF/ID/EX while a MULT/DIV is in flight.

## Interface
- WIDTH, 32: datapath width; must be a power of two ≥ 8.
- SHAMT_W, $clog2(WIDTH): derived shift-amount width; not overridden.
- clock__i  in  1  rising-edge clock
- reset_n__i  in  1  asynchronous, active-low reset
- dataA__i  in  WIDTH  operand A (rs)
- dataB__i  in  WIDTH  operand B (rt or sign-extended immediate)
- ALUCtrl__i  in  4  operation code
- start__i  in  1  launch a MULT/MULTU/DIV/DIVU; ignored for other codes
- ALUResult__o  out  WIDTH  single-cycle result (combinational)
- Zero__o  out  1  ALUResult__o == 0
- Overflow__o  out  1  signed overflow, ADD/SUB only; otherwise 0
- busy__o  out  1  mul/div in progress
- done__o  out  1  one-cycle pulse; HI/LO just updated
- hi__o  out  WIDTH  HI register (remainder / product upper half)
- lo__o  out  WIDTH  LO register (quotient / product lower half)

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD (also LW/SW), 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB (also BEQ), 0111 SLT, 1000 SLL, 1001 SRL, 1010 SRA, 1011 MULT, 1100 MULTU, 1101 DIV, 1110 DIVU, 1111 reserved.
- Reserved code: ALUResult__o = 1, Zero__o = 0.
- Arithmetic wraps modulo 2^WIDTH.
- Overflow__o:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
- SLT: signed compare A < B, computed from sign bits plus the subtraction (no overflow error). Result is 1 or 0, zero-extended.
- SLTU: unsigned compare A < B.
- Shifts: value = dataA__i, amount = dataB__i[SHAMT_W-1:0]; upper bits of B ignored. SRA replicates the sign bit.
- Mul/div codes: ALUResult__o = 0, Zero__o = 1.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE → RUN when start__i=1 and ALUCtrl__i is 1011–1110. Operands and op are latched; the iteration counter is loaded with WIDTH.
  - RUN → DONE when the counter reaches 0. HI/LO are written on that edge.
  - DONE → IDLE otherwise.
- start__i during RUN is ignored; no queueing.
- MULT/MULTU: {HI,LO} = full 2·WIDTH product. Shift-add iteration, one bit per cycle; signed MULT operates on magnitudes and negates the product when operand signs differ.
- DIV/DIVU: restoring division, one quotient bit per cycle. LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend; same latency; no exception.
- Signed DIV of MIN by −1: LO = MIN, HI = 0.
- HI/LO change only on the RUN→DONE edge or on reset.

## Timing
- Single-cycle ops: zero latency, purely combinational from dataA/dataB/ALUCtrl; unaffected by FSM state.
- Launch edge k (start sampled). busy__o = 1 for cycles k+1 … k+WIDTH.
- done__o = 1 in cycle k+WIDTH+1 only; hi__o/lo__o hold the new values from that cycle on.
- A new start__i is accepted in the DONE cycle, giving back-to-back ops every WIDTH+1 cycles.
- Reset (any time, including mid-RUN): state IDLE, busy__o = 0, done__o = 0, hi__o = 0, lo__o = 0, counter = 0. The in-flight op is aborted with no partial HI/LO write.
- The first edge after reset deasserts is a normal edge; start__i may be sampled on it.

## Test plan
- Sweep single-cycle ops (WIDTH=32):
  - ADD 0x7FFFFFFF+1 → 0x80000000, Overflow=1.
  - SUB 5−5 → 0, Zero=1.
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLL by dataB=0x21 → shift by 1.
- MULT −3×7: start at edge k → busy for 32 cycles, done at k+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=1.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- Back-to-back: second start issued in the DONE cycle is accepted. start pulsed during RUN is ignored, and HI/LO match the first op only.
- Assert reset_n__i low at cycle k+10 of a MULT: busy/done/HI/LO go to 0 immediately (asynchronously). After release, a fresh DIVU 100/7 gives LO=14, HI=2.
- WIDTH=8 build: MULTU 0xFF×0xFF → HI=0xFE, LO=0x01 with done at k+9. Reserved code 1111 → ALUResult=1, Zero=0.

Source files
------------

// File: rtl/alu_muldiv_if.sv
// Execute-stage ALU bus: single-cycle operands/results plus the mul/div launch and completion signals.
// The master side drives operands and start__i; the slave side (the ALU) drives everything else.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dataA__i;
  logic [WIDTH-1:0] dataB__i;
  logic [3:0]       ALUCtrl__i;
  logic             start__i;
  logic [WIDTH-1:0] ALUResult__o;
  logic             Zero__o;
  logic             Overflow__o;
  logic             busy__o;
  logic             done__o;
  logic [WIDTH-1:0] hi__o;
  logic [WIDTH-1:0] lo__o;
  logic [1:0]       state_dbg__o;

  // Handshake: a launch is a rising clock edge with start__i=1, a mul/div ALUCtrl__i and busy__o=0.
  // busy__o acts as not-ready; start__i is dropped (never queued) while busy__o=1.
  // done__o is a one-cycle valid for hi__o/lo__o.
  modport master (
    output dataA__i, dataB__i, ALUCtrl__i, start__i,
    input  ALUResult__o, Zero__o, Overflow__o, busy__o, done__o, hi__o, lo__o, state_dbg__o
  );

  modport slave (
    input  dataA__i, dataB__i, ALUCtrl__i, start__i,
    output ALUResult__o, Zero__o, Overflow__o, busy__o, done__o, hi__o, lo__o, state_dbg__o
  );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS execute-stage ALU: combinational integer ops plus an iterative radix-2 multiply/divide
// unit that owns the architectural HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic          clock__i,
  input logic          reset_n__i,
  alu_muldiv_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  logic [WIDTH-1:0] a, b, sum, diff, alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic alu_ovf;

  always_comb begin
    a       = bus.dataA__i;
    b       = bus.dataB__i;
    sum     = a + b;
    diff    = a - b;
    shamt   = b[SHAMT_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUCtrl__i)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // Differing signs decide directly; equal signs cannot overflow, so the difference sign is exact.
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1]};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_res = '0;
      default: alu_res = {{(WIDTH-1){1'b0}}, 1'b1};
    endcase
  end

  assign bus.ALUResult__o = alu_res;
  assign bus.Zero__o      = (alu_res == '0);
  assign bus.Overflow__o  = alu_ovf;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic is_mul_q, is_mul_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

  // acc holds the running HI half (product) or partial remainder; quo holds the LO half / quotient bits.
  logic [WIDTH:0]     msum, shifted, trial;
  logic               ge, unused_trial_msb;
  logic [WIDTH-1:0]   step_acc, step_quo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    msum     = {1'b0, acc_q} + {1'b0, (quo_q[0] ? dvsr_q : {WIDTH{1'b0}})};
    shifted  = {acc_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    ge       = (shifted >= {1'b0, dvsr_q});
    unused_trial_msb = trial[WIDTH];
    prod     = '0;
    if (is_mul_q) begin
      step_acc = msum[WIDTH:1];
      step_quo = {msum[0], quo_q[WIDTH-1:1]};
      prod     = {step_acc, step_quo};
      if (neg_res_q) prod = -prod;
      fin_hi   = prod[2*WIDTH-1:WIDTH];
      fin_lo   = prod[WIDTH-1:0];
    end else begin
      step_acc = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], ge};
      // With a zero divisor every trial succeeds, leaving |dividend| as remainder; LO is forced.
      fin_lo   = div0_q ? {WIDTH{1'b1}} : (neg_res_q ? -step_quo : step_quo);
      fin_hi   = neg_rem_q ? -step_acc : step_acc;
    end
  end

  logic             launch, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    signed_op = (bus.ALUCtrl__i == OP_MULT) || (bus.ALUCtrl__i == OP_DIV);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    launch    = (state_q != RUN) && bus.start__i &&
                (bus.ALUCtrl__i >= OP_MULT) && (bus.ALUCtrl__i <= OP_DIVU);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    is_mul_d  = is_mul_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE, DONE: begin
        if (launch) begin
          state_d   = RUN;
          cnt_d     = CNT_W'(WIDTH);
          is_mul_d  = (bus.ALUCtrl__i == OP_MULT) || (bus.ALUCtrl__i == OP_MULTU);
          acc_d     = '0;
          quo_d     = is_mul_d ? b_mag : a_mag;
          dvsr_d    = is_mul_d ? a_mag : b_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (b == '0);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step_acc;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          hi_d    = fin_hi;
          lo_d    = fin_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_mul_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      is_mul_q  <= is_mul_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy__o      = (state_q == RUN);
  assign bus.done__o      = (state_q == DONE);
  assign bus.hi__o        = hi_q;
  assign bus.lo__o        = lo_q;
  assign bus.state_dbg__o = state_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised bench for alu_muldiv against a plain-arithmetic reference model, with
// directed corner cases for the combinational ops and the HI/LO mul/div unit.
module tb_alu_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [2*W-1:0] exp_q[$];

  alu_muldiv_if #(.WIDTH(W)) bus ();
  alu_muldiv_if #(.WIDTH(8)) bus8 ();

  alu_muldiv #(.WIDTH(W)) dut (.clock__i(clk), .reset_n__i(rst_n), .bus(bus));
  alu_muldiv #(.WIDTH(8)) dut8 (.clock__i(clk), .reset_n__i(rst_n), .bus(bus8));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic z, output logic ov);
    longint sa, sb, s;
    logic [4:0] sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    ov = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin r = a + b; s = sa + sb; ov = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000); end
      4'd3:  r = a ^ b;
      4'd4:  r = ~(a | b);
      4'd5:  r = (a < b) ? 1 : 0;
      4'd6:  begin r = a - b; s = sa - sb; ov = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000); end
      4'd7:  r = (sa < sb) ? 1 : 0;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: r = $signed(a) >>> sh;
      4'd15: r = 1;
      default: r = 0;
    endcase
    z = (r == 0);
  endfunction

  function automatic logic [2*W-1:0] ref_muldiv(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [2*W-1:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd11: begin q = sa * sb; p = q; end
      4'd12: p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      4'd13: begin
        if (b == 0) p = {a, {W{1'b1}}};
        else begin q = sa / sb; r = sa % sb; p = {r[W-1:0], q[W-1:0]}; end
      end
      default: begin
        if (b == 0) p = {a, {W{1'b1}}};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return W'($urandom_range(0, 300));
      6: return -W'($urandom_range(1, 300));
      default: return $urandom;
    endcase
  endfunction

  // driver tasks
  task automatic alu_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic z, ov;
    bus.ALUCtrl__i = op;
    bus.dataA__i   = a;
    bus.dataB__i   = b;
    #1;
    ref_alu(op, a, b, r, z, ov);
    check_eq($sformatf("alu_res op%0d", op), bus.ALUResult__o, r);
    check_eq($sformatf("alu_zero op%0d", op), bus.Zero__o, z);
    check_eq($sformatf("alu_ovf op%0d", op), bus.Overflow__o, ov);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_muldiv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int glitch);
    logic [W-1:0]   ph, pl;
    logic [2*W-1:0] e;
    int cycles, busy_cnt;
    bit hl_moved;
    exp_q.push_back(ref_muldiv(op, a, b));
    ph = bus.hi__o;
    pl = bus.lo__o;
    bus.ALUCtrl__i = op;
    bus.dataA__i   = a;
    bus.dataB__i   = b;
    bus.start__i   = 1'b1;
    @(posedge clk);
    #1;
    bus.start__i   = 1'b0;
    bus.dataA__i   = $urandom;
    bus.dataB__i   = $urandom;
    bus.ALUCtrl__i = 4'd0;
    @(negedge clk);
    cycles = 1;
    busy_cnt = 0;
    hl_moved = 0;
    while (!bus.done__o && cycles < 4 * W) begin
      if (bus.busy__o) busy_cnt++;
      if (bus.hi__o !== ph || bus.lo__o !== pl) hl_moved = 1;
      if (cycles == glitch) begin
        bus.start__i   = 1'b1;
        bus.ALUCtrl__i = 4'b1101;
        bus.dataA__i   = $urandom;
        bus.dataB__i   = $urandom;
      end else begin
        bus.start__i = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    bus.start__i = 1'b0;
    check_eq("md_latency", cycles, W + 1);
    check_eq("md_busy_cycles", busy_cnt, W);
    check_eq("md_hilo_held_in_run", hl_moved, 0);
    check_eq("md_busy_in_done", bus.busy__o, 0);
    e = exp_q.pop_front();
    check_eq($sformatf("md_hi op%0d", op), bus.hi__o, e[2*W-1:W]);
    check_eq($sformatf("md_lo op%0d", op), bus.lo__o, e[W-1:0]);
  endtask

  initial begin
    int cycles;
    logic [15:0] p8;
    bus.start__i = 1'b0;  bus.ALUCtrl__i = 4'd0;  bus.dataA__i = '0;  bus.dataB__i = '0;
    bus8.start__i = 1'b0; bus8.ALUCtrl__i = 4'd0; bus8.dataA__i = '0; bus8.dataB__i = '0;

    // reset state
    #3;
    check_eq("rst_busy", bus.busy__o, 0);
    check_eq("rst_done", bus.done__o, 0);
    check_eq("rst_hi", bus.hi__o, 0);
    check_eq("rst_lo", bus.lo__o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed single-cycle corners
    alu_vec(4'd2, 32'h7FFF_FFFF, 32'h1);
    check_eq("add_max_plus_1", bus.ALUResult__o, 32'h8000_0000);
    alu_vec(4'd6, 32'd5, 32'd5);
    check_eq("sub_zero_flag", bus.Zero__o, 1);
    alu_vec(4'd6, 32'h8000_0000, 32'h1);
    alu_vec(4'd7, 32'hFFFF_FFFF, 32'h1);
    check_eq("slt_neg1_lt_1", bus.ALUResult__o, 1);
    alu_vec(4'd5, 32'hFFFF_FFFF, 32'h1);
    check_eq("sltu_ffff_vs_1", bus.ALUResult__o, 0);
    alu_vec(4'd10, 32'h8000_0000, 32'd4);
    check_eq("sra_sign_fill", bus.ALUResult__o, 32'hF800_0000);
    alu_vec(4'd8, 32'h0000_0003, 32'h21);
    check_eq("sll_shamt_masked", bus.ALUResult__o, 32'h6);
    alu_vec(4'd15, 32'h0, 32'h0);
    check_eq("reserved_zero", bus.Zero__o, 0);
    alu_vec(4'd13, 32'h5, 32'h3);

    // random single-cycle ops
    for (int i = 0; i < 300; i++) alu_vec(4'($urandom_range(0, 15)), pick_operand(), pick_operand());

    // directed mul/div
    @(negedge clk);
    do_muldiv(4'd11, -32'sd3, 32'd7, 0);
    @(negedge clk);
    do_muldiv(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    do_muldiv(4'd13, -32'sd7, 32'd2, 0);
    @(negedge clk);
    do_muldiv(4'd14, 32'd7, 32'd0, 0);
    @(negedge clk);
    do_muldiv(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    do_muldiv(4'd13, 32'hFFFF_FFF0, 32'd0, 0);

    // back-to-back: second launch in the DONE cycle
    do_muldiv(4'd11, 32'h8000_0000, 32'h8000_0000, 0);
    do_muldiv(4'd14, 32'hDEAD_BEEF, 32'd1234, 0);

    // start pulsed during RUN is dropped
    @(negedge clk);
    do_muldiv(4'd13, 32'd1000, -32'sd9, 5);
    @(negedge clk);
    check_eq("no_queued_op_busy", bus.busy__o, 0);
    check_eq("no_queued_op_done", bus.done__o, 0);

    // random mul/div
    for (int i = 0; i < 14; i++) begin
      do_muldiv(4'($urandom_range(11, 14)), pick_operand(), pick_operand(), 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // asynchronous reset in the middle of a MULT
    @(negedge clk);
    bus.ALUCtrl__i = 4'd11; bus.dataA__i = 32'h1234_5678; bus.dataB__i = 32'h9ABC_DEF0;
    bus.start__i = 1'b1;
    @(posedge clk);
    #1 bus.start__i = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrun_rst_busy", bus.busy__o, 0);
    check_eq("midrun_rst_done", bus.done__o, 0);
    check_eq("midrun_rst_hi", bus.hi__o, 0);
    check_eq("midrun_rst_lo", bus.lo__o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_muldiv(4'd14, 32'd100, 32'd7, 0);
    check_eq("divu_100_7_lo", bus.lo__o, 14);
    check_eq("divu_100_7_hi", bus.hi__o, 2);

    // narrow build
    @(negedge clk);
    p8 = {8'h00, 8'hFF} * {8'h00, 8'hFF};
    bus8.ALUCtrl__i = 4'd12; bus8.dataA__i = 8'hFF; bus8.dataB__i = 8'hFF; bus8.start__i = 1'b1;
    @(posedge clk);
    #1 bus8.start__i = 1'b0;
    @(negedge clk);
    cycles = 1;
    while (!bus8.done__o && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("w8_latency", cycles, 9);
    check_eq("w8_hi", bus8.hi__o, p8[15:8]);
    check_eq("w8_lo", bus8.lo__o, p8[7:0]);
    bus8.ALUCtrl__i = 4'd15;
    #1;
    check_eq("w8_reserved_res", bus8.ALUResult__o, 8'h01);
    check_eq("w8_reserved_zero", bus8.Zero__o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
